seq_alu: RTL

//  Parametrised multi-cycle ALU for the CPU datapath; the next generation of the

---
 rtl/seq_alu.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, bit-serial shifts and a shift-add unsigned
// multiply, with a start/done handshake and registered result/flags.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rsdata,
    input  logic [WIDTH-1:0] rmdata,
    input  logic [WIDTH-1:0] N,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    localparam logic [2:0]   OP_LSL  = 3'b100;
    localparam logic [2:0]   OP_MUL  = 3'b101;
    localparam logic [2:0]   OP_LSR  = 3'b110;
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] imm_res;
    logic             imm_carry;

    // acc holds the shift value, or the multiplicand that moves left each MUL step
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] prod;
    logic [SHW:0]     cnt;
    logic             shr_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] prod_nxt;

    assign accept    = start && (state == IDLE || state == DONE);
    assign amt       = N[SHW-1:0];
    assign operand_b = op[0] ? N : rmdata;
    assign shift_nxt = shr_q ? (acc >> 1) : (acc << 1);
    assign prod_nxt  = mplr[0] ? (prod + acc) : prod;

    // Single-cycle ops; SUB carry is the carry-out of A + ~B + 1, i.e. no-borrow.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        imm_res   = '0;
        imm_carry = 1'b0;
        case (op)
            3'b000, 3'b001: {imm_carry, imm_res} = {1'b0, rsdata} + {1'b0, operand_b};
            3'b010, 3'b011: {imm_carry, imm_res} = {1'b0, rsdata} + {1'b0, ~operand_b}
                                                   + (WIDTH+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, not asynchronously.
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    case (op)
                        OP_LSL, OP_LSR: state_nxt = (amt == '0) ? DONE : SHIFT;
                        OP_MUL:         state_nxt = MUL;
                        default:        state_nxt = DONE;
                    endcase
                end
            end
            SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
            MUL:     if (cnt == CNT_ONE) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == MUL);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            aluout <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            acc    <= '0;
            mplr   <= '0;
            prod   <= '0;
            cnt    <= '0;
            shr_q  <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            shr_q <= op[1];
            case (op)
                OP_LSL, OP_LSR: begin
                    if (amt == '0) begin
                        aluout <= rsdata;
                        zero   <= (rsdata == '0);
                        carry  <= 1'b0;
                    end else begin
                        acc <= rsdata;
                        cnt <= {1'b0, amt};
                    end
                end
                OP_MUL: begin
                    acc  <= rsdata;
                    mplr <= rmdata;
                    prod <= '0;
                    cnt  <= CNT_MUL;
                end
                default: begin
                    aluout <= imm_res;
                    zero   <= (imm_res == '0);
                    carry  <= imm_carry;
                end
            endcase
        end else begin
            case (state)
                SHIFT: begin
                    acc <= shift_nxt;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        aluout <= shift_nxt;
                        zero   <= (shift_nxt == '0);
                        carry  <= 1'b0;
                    end
                end
                MUL: begin
                    prod <= prod_nxt;
                    acc  <= acc << 1;
                    mplr <= mplr >> 1;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        aluout <= prod_nxt;
                        zero   <= (prod_nxt == '0);
                        carry  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
